// File: rtl/axis_uart_pkg.sv
// Shared definitions for the packetised AXI-Stream UART transmitter:
// FSM state encoding, parity selections and the baud divider helper.
package axis_uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_GAP    = 3'd5
  } tx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Rounded clk cycles per line bit.
  function automatic int calc_div(input int clk_rate, input int baud);
    return (clk_rate + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_pkt_fifo.sv
// Synchronous first-word-fall-through FIFO holding {last, data} entries.
// Writes when full and reads when empty are ignored.
module uart_pkt_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_wr;
  logic             w_rd;

  assign o_full    = (r_level == (AW+1)'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_rd_data = r_mem[r_rd_ptr];
  assign w_wr      = i_wr_en && !o_full;
  assign w_rd      = i_rd_en && !o_empty;

  // Storage is not reset; occupancy alone defines what is valid.
  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/axis_uart_tx_pkt.sv
// AXI-Stream to UART transmitter with a packet FIFO, optional packet hold
// and idle gap after each end-of-packet byte.
//   state  | meaning
//   IDLE   | line high, pops the head entry when eligible
//   START  | start bit (0)
//   DATA   | DATA_BITS data bits, LSB first
//   PARITY | even/odd parity bit (skipped when none)
//   STOP   | stop bit(s), line high
//   GAP    | idle bit-times after a last byte
module axis_uart_tx_pkt
  import axis_uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CLK_RATE   = 100000000,
  parameter int BAUD       = 115200,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int PKT_MODE   = 0,
  parameter int GAP_BITS   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          s_axis_data,
  input  logic                          s_axis_valid,
  input  logic                          s_axis_last,
  output logic                          s_axis_ready,
  output logic                          uart_tx,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          tx_busy
);

  localparam int DIV      = calc_div(CLK_RATE, BAUD);
  localparam int LW       = $clog2(FIFO_DEPTH) + 1;
  localparam int BW       = $clog2(DATA_BITS);
  localparam int MAX_MULT = (GAP_BITS > STOP_BITS) ? GAP_BITS : STOP_BITS;
  localparam int CNT_W    = $clog2(MAX_MULT * DIV + 1);
  localparam logic [CNT_W-1:0] C_BIT  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] C_STOP = CNT_W'(STOP_BITS * DIV - 1);
  localparam logic [CNT_W-1:0] C_GAP  = (GAP_BITS > 0) ? CNT_W'(GAP_BITS * DIV - 1) : '0;

  tx_state_t            r_state;
  tx_state_t            w_state_nxt;
  logic [CNT_W-1:0]     r_baud;
  logic [CNT_W-1:0]     w_baud_nxt;
  logic [BW-1:0]        r_bit;
  logic [BW-1:0]        w_bit_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 r_par;
  logic                 w_par_nxt;
  logic                 r_last;
  logic                 w_last_nxt;
  logic                 r_tx;
  logic                 w_tx_nxt;
  logic                 r_rdy_en;
  logic [LW-1:0]        r_pkt_cnt;

  logic                 w_pop;
  logic                 w_wr;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_eligible;
  logic                 w_tc;
  logic [DATA_BITS:0]   w_head;
  logic [LW-1:0]        w_level;

  uart_pkt_fifo #(
    .WIDTH (DATA_BITS + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (clk),
    .i_rst_n   (rst),
    .i_wr_en   (w_wr),
    .i_wr_data ({s_axis_last, s_axis_data}),
    .i_rd_en   (w_pop),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_level   (w_level)
  );

  assign s_axis_ready = r_rdy_en && !w_full;
  assign w_wr         = s_axis_valid && s_axis_ready;
  assign fifo_level   = w_level;
  assign uart_tx      = r_tx;
  assign tx_busy      = (r_state != S_IDLE);
  assign w_tc         = (r_baud == '0);

  // A full FIFO with no complete packet would otherwise never drain.
  assign w_eligible = !w_empty &&
                      ((PKT_MODE == 0) || (r_pkt_cnt != '0) || w_full);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = w_tc ? r_baud : r_baud - CNT_W'(1);
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_par_nxt   = r_par;
    w_last_nxt  = r_last;
    w_tx_nxt    = r_tx;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tx_nxt = 1'b1;
        if (w_eligible) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
          w_baud_nxt  = C_BIT;
          w_tx_nxt    = 1'b0;
          w_shift_nxt = w_head[DATA_BITS-1:0];
          w_last_nxt  = w_head[DATA_BITS];
          w_par_nxt   = (^w_head[DATA_BITS-1:0]) ^ (PARITY == PARITY_ODD);
        end
      end
      S_START: begin
        if (w_tc) begin
          w_state_nxt = S_DATA;
          w_baud_nxt  = C_BIT;
          w_bit_nxt   = '0;
          w_tx_nxt    = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_tc) begin
          if (r_bit == BW'(DATA_BITS - 1)) begin
            if (PARITY != PARITY_NONE) begin
              w_state_nxt = S_PARITY;
              w_baud_nxt  = C_BIT;
              w_tx_nxt    = r_par;
            end else begin
              w_state_nxt = S_STOP;
              w_baud_nxt  = C_STOP;
              w_tx_nxt    = 1'b1;
            end
          end else begin
            w_bit_nxt   = r_bit + BW'(1);
            w_shift_nxt = r_shift >> 1;
            w_baud_nxt  = C_BIT;
            w_tx_nxt    = r_shift[1];
          end
        end
      end
      S_PARITY: begin
        if (w_tc) begin
          w_state_nxt = S_STOP;
          w_baud_nxt  = C_STOP;
          w_tx_nxt    = 1'b1;
        end
      end
      S_STOP: begin
        w_tx_nxt = 1'b1;
        if (w_tc) begin
          if (r_last && (GAP_BITS > 0)) begin
            w_state_nxt = S_GAP;
            w_baud_nxt  = C_GAP;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_GAP: begin
        w_tx_nxt = 1'b1;
        if (w_tc) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_baud    <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_last    <= 1'b0;
      r_tx      <= 1'b1;
      r_rdy_en  <= 1'b0;
      r_pkt_cnt <= '0;
    end else begin
      r_baud   <= w_baud_nxt;
      r_bit    <= w_bit_nxt;
      r_shift  <= w_shift_nxt;
      r_par    <= w_par_nxt;
      r_last   <= w_last_nxt;
      r_tx     <= w_tx_nxt;
      r_rdy_en <= 1'b1;
      case ({w_wr && s_axis_last, w_pop && w_head[DATA_BITS]})
        2'b10:   r_pkt_cnt <= r_pkt_cnt + LW'(1);
        2'b01:   r_pkt_cnt <= r_pkt_cnt - LW'(1);
        default: r_pkt_cnt <= r_pkt_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_uart_tx_pkt.sv
// Directed bench: five transmitter configurations at DIV=10 checked against
// hand-computed line waveforms, FIFO behaviour and reset recovery.
module tb_axis_uart_tx_pkt;

  logic       clk;
  logic       rst;
  logic [7:0] dat [5];
  logic [4:0] vld;
  logic [4:0] lst;
  logic [4:0] w_rdy;
  logic [4:0] w_tx;
  logic [4:0] w_busy;
  logic [2:0] lvl_a;
  logic [4:0] lvl_e;
  logic [4:0] lvl_o;
  logic [3:0] lvl_p;
  logic [4:0] lvl_g;

  int n_vec = 0;
  int n_mis = 0;
  int cyc   = 0;
  int run      [5] = '{default: 0};
  int last_run [5] = '{default: 0};
  int lowcnt   [5] = '{default: 0};

  // 0: 8N1 depth 4 | 1: even parity, 2 stop | 2: odd parity | 3: packet mode | 4: gap 3
  axis_uart_tx_pkt #(.FIFO_DEPTH(4), .CLK_RATE(1000000), .BAUD(100000)) u_a (
    .clk(clk), .rst(rst), .s_axis_data(dat[0]), .s_axis_valid(vld[0]), .s_axis_last(lst[0]),
    .s_axis_ready(w_rdy[0]), .uart_tx(w_tx[0]), .fifo_level(lvl_a), .tx_busy(w_busy[0]));
  axis_uart_tx_pkt #(.CLK_RATE(1000000), .BAUD(100000), .PARITY(1), .STOP_BITS(2)) u_e (
    .clk(clk), .rst(rst), .s_axis_data(dat[1]), .s_axis_valid(vld[1]), .s_axis_last(lst[1]),
    .s_axis_ready(w_rdy[1]), .uart_tx(w_tx[1]), .fifo_level(lvl_e), .tx_busy(w_busy[1]));
  axis_uart_tx_pkt #(.CLK_RATE(1000000), .BAUD(100000), .PARITY(2)) u_o (
    .clk(clk), .rst(rst), .s_axis_data(dat[2]), .s_axis_valid(vld[2]), .s_axis_last(lst[2]),
    .s_axis_ready(w_rdy[2]), .uart_tx(w_tx[2]), .fifo_level(lvl_o), .tx_busy(w_busy[2]));
  axis_uart_tx_pkt #(.FIFO_DEPTH(8), .CLK_RATE(1000000), .BAUD(100000), .PKT_MODE(1)) u_p (
    .clk(clk), .rst(rst), .s_axis_data(dat[3]), .s_axis_valid(vld[3]), .s_axis_last(lst[3]),
    .s_axis_ready(w_rdy[3]), .uart_tx(w_tx[3]), .fifo_level(lvl_p), .tx_busy(w_busy[3]));
  axis_uart_tx_pkt #(.CLK_RATE(1000000), .BAUD(100000), .GAP_BITS(3)) u_g (
    .clk(clk), .rst(rst), .s_axis_data(dat[4]), .s_axis_valid(vld[4]), .s_axis_last(lst[4]),
    .s_axis_ready(w_rdy[4]), .uart_tx(w_tx[4]), .fifo_level(lvl_g), .tx_busy(w_busy[4]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int s = 0; s < 5; s++) begin
      if (w_busy[s]) run[s] = run[s] + 1;
      else begin
        if (run[s] != 0) last_run[s] = run[s];
        run[s] = 0;
      end
      if (!w_tx[s]) lowcnt[s] = lowcnt[s] + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int s, input logic [7:0] d, input logic l);
    int g;
    @(negedge clk);
    dat[s] = d;
    lst[s] = l;
    vld[s] = 1'b1;
    g = 0;
    while (!w_rdy[s] && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 3000) check_val("push_timeout", 32'(g), 32'(0));
  endtask

  task automatic idle_in(input int s);
    @(negedge clk);
    vld[s] = 1'b0;
    lst[s] = 1'b0;
  endtask

  // Waits for a start bit, then samples nsamp bit centres (start bit first).
  task automatic rx_frame(input int s, input int nsamp, output logic [15:0] bits,
                          output int t_start, output int low0);
    int  g;
    bit  first;
    bits = '0; t_start = -1; low0 = 0; first = 1'b1;
    @(negedge clk);
    g = 0;
    while (w_tx[s] !== 1'b1 && g < 5000) begin @(negedge clk); g++; end
    while (w_tx[s] !== 1'b0 && g < 5000) begin @(negedge clk); g++; end
    if (g >= 5000) begin
      check_val("rx_timeout", 32'(g), 32'(0));
      return;
    end
    t_start = cyc;
    for (int i = 0; i <= 10 * (nsamp - 1) + 5; i++) begin
      if (i > 0) @(negedge clk);
      if (first) begin
        if (w_tx[s] == 1'b0) low0++;
        else first = 1'b0;
      end
      if (i % 10 == 5) bits[i / 10] = w_tx[s];
    end
  endtask

  logic [15:0] b0, b1, b2;
  int          t0, t1, t2, l0, l1, l2;
  int          k, k_full, lvl_full, wcyc, snap, g;
  logic [7:0]  burst [6] = '{8'h01, 8'h80, 8'h7E, 8'hC3, 8'h55, 8'h99};
  logic [7:0]  seq   [7] = '{8'h3C, 8'h01, 8'h80, 8'h7E, 8'hC3, 8'h55, 8'h99};
  logic [7:0]  got   [7];
  logic [7:0]  gb    [3];
  int          gt    [3];

  initial begin
    rst = 1'b0;
    vld = '0;
    lst = '0;
    for (int s = 0; s < 5; s++) dat[s] = 8'h00;
    repeat (3) @(negedge clk);
    check_val("rst_ready_low", 32'(w_rdy[0]), 32'(0));
    check_val("rst_tx_high",   32'(w_tx[0]),  32'(1));
    check_val("rst_level",     32'(lvl_a),    32'(0));
    check_val("rst_busy",      32'(w_busy[0]), 32'(0));
    rst = 1'b1;
    @(negedge clk);
    check_val("ready_after_rst", 32'(w_rdy[0]), 32'(1));

    // 8N1 0xA5: start 0, then 1,0,1,0,0,1,0,1, busy 10+80+10 clk
    fork
      begin push(0, 8'hA5, 1'b0); idle_in(0); end
      rx_frame(0, 9, b0, t0, l0);
    join
    check_val("a5_bits",      32'(b0[8:0]), 32'h14A);
    check_val("a5_start_len", 32'(l0),      32'(10));
    repeat (30) @(negedge clk);
    check_val("a5_busy_len",  32'(last_run[0]), 32'(100));

    // 0x07: even parity 1 -> {1,07,0}=0x20E; odd parity 0 -> 0x00E
    fork
      begin push(1, 8'h07, 1'b0); idle_in(1); end
      begin push(2, 8'h07, 1'b0); idle_in(2); end
      rx_frame(1, 10, b1, t1, l1);
      rx_frame(2, 10, b2, t2, l2);
    join
    check_val("even_par_bits", 32'(b1[9:0]), 32'h20E);
    check_val("odd_par_bits",  32'(b2[9:0]), 32'h00E);
    repeat (40) @(negedge clk);
    check_val("stop2_busy_len", 32'(last_run[1]), 32'(120));
    check_val("odd_busy_len",   32'(last_run[2]), 32'(110));

    // Leader byte keeps the transmitter busy so the burst fills the depth-4 FIFO.
    k_full = -1; lvl_full = -1;
    fork
      begin
        push(0, 8'h3C, 1'b0);
        idle_in(0);
        repeat (3) @(negedge clk);
        k = 0; g = 0;
        while (k < 6 && g < 3000) begin
          @(negedge clk);
          g++;
          dat[0] = burst[k];
          vld[0] = 1'b1;
          if (!w_rdy[0] && k_full < 0) begin
            k_full   = k;
            lvl_full = int'(lvl_a);
          end
          if (w_rdy[0]) k++;
        end
        @(negedge clk);
        vld[0] = 1'b0;
      end
      begin
        for (int f = 0; f < 7; f++) begin
          rx_frame(0, 9, b0, t0, l0);
          got[f] = b0[8:1];
        end
      end
    join
    check_val("burst_writes_at_full", 32'(k_full),   32'(4));
    check_val("burst_level_at_full",  32'(lvl_full), 32'(4));
    check_val("burst_accepted",       32'(k),        32'(6));
    for (int f = 0; f < 7; f++) check_val($sformatf("burst_byte%0d", f), 32'(got[f]), 32'(seq[f]));

    // Packet mode: three non-last bytes are held back.
    push(3, 8'h41, 1'b0);
    push(3, 8'h42, 1'b0);
    push(3, 8'h43, 1'b0);
    idle_in(3);
    snap = lowcnt[3];
    repeat (50) @(negedge clk);
    check_val("pkt_hold_line",  32'(lowcnt[3] - snap), 32'(0));
    check_val("pkt_hold_level", 32'(lvl_p), 32'(3));
    fork
      begin
        push(3, 8'h44, 1'b1);
        @(negedge clk);
        wcyc = cyc;
        vld[3] = 1'b0;
        lst[3] = 1'b0;
      end
      rx_frame(3, 9, b0, t0, l0);
    join
    check_val("pkt_start_latency", 32'(t0 - wcyc), 32'(1));
    check_val("pkt_first_byte",    32'(b0[8:1]),   32'h41);

    // Gap: 0x11 -> 0x22 start-to-start 100+1; 0x22(last) -> 0x33 100+30+1
    fork
      begin
        push(4, 8'h11, 1'b0);
        push(4, 8'h22, 1'b1);
        push(4, 8'h33, 1'b0);
        idle_in(4);
      end
      begin
        for (int f = 0; f < 3; f++) begin
          rx_frame(4, 9, b0, t0, l0);
          gb[f] = b0[8:1];
          gt[f] = t0;
        end
      end
    join
    check_val("gap_byte0", 32'(gb[0]), 32'h11);
    check_val("gap_byte1", 32'(gb[1]), 32'h22);
    check_val("gap_byte2", 32'(gb[2]), 32'h33);
    check_val("gap_nolast_spacing", 32'(gt[1] - gt[0]), 32'(101));
    check_val("gap_last_spacing",   32'(gt[2] - gt[1]), 32'(131));
    repeat (120) @(negedge clk);

    // Reset in data bit 4 of an all-zero frame while 0xFF waits in the FIFO.
    fork
      begin
        push(0, 8'h00, 1'b0);
        push(0, 8'hFF, 1'b0);
        idle_in(0);
      end
      begin
        @(negedge clk);
        g = 0;
        while (w_tx[0] !== 1'b0 && g < 2000) begin @(negedge clk); g++; end
        if (g >= 2000) check_val("rst_wait_timeout", 32'(g), 32'(0));
        repeat (55) @(negedge clk);
      end
    join
    check_val("rst_pre_line",  32'(w_tx[0]), 32'(0));
    check_val("rst_pre_level", 32'(lvl_a),   32'(1));
    #2 rst = 1'b0;
    #1;
    check_val("rst_mid_tx",    32'(w_tx[0]),   32'(1));
    check_val("rst_mid_level", 32'(lvl_a),     32'(0));
    check_val("rst_mid_ready", 32'(w_rdy[0]),  32'(0));
    check_val("rst_mid_busy",  32'(w_busy[0]), 32'(0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("rst_rel_ready", 32'(w_rdy[0]), 32'(1));
    check_val("rst_rel_level", 32'(lvl_a),    32'(0));
    snap = lowcnt[0];
    repeat (300) @(negedge clk);
    check_val("rst_no_frame", 32'(lowcnt[0] - snap), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/axis_uart_tx_pkt.md
AXIS_UART_TX_PKT -- requirements
Module: axis_uart_tx_pkt

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning UART data bits per frame (legal 5..9).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning FIFO entries (power of 2, at least 2).
REQ-003 SHALL have parameter CLK_RATE, default 100000000, meaning clk frequency in Hz.
REQ-004 SHALL have parameter BAUD, default 115200, meaning line bit rate.
REQ-005 SHALL have parameter PARITY, default 0, meaning 0 none, 1 even, 2 odd.
REQ-006 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame (1 or 2).
REQ-007 SHALL have parameter PKT_MODE, default 0, meaning 1 holds transmission until a whole packet is buffered.
REQ-008 SHALL have parameter GAP_BITS, default 0, meaning idle bit-times inserted after each tlast byte (0..255).
REQ-009 SHALL have port clk, input, 1, the single clock.
REQ-010 SHALL have port rst, input, 1, the reset: asynchronous and active-low.
REQ-011 SHALL have ports s_axis_data (input, DATA_BITS), s_axis_valid (input, 1), s_axis_last (input, 1) and s_axis_ready (output, 1), forming the AXI-Stream slave.
REQ-012 SHALL have port uart_tx, output, 1, the serial line, idle high.
REQ-013 SHALL have port fifo_level, output, clog2(FIFO_DEPTH)+1, the current occupancy.
REQ-014 SHALL have port tx_busy, output, 1, high whenever the state is not IDLE.

Function
REQ-015 SHALL assert s_axis_ready whenever the FIFO is not full, with no dependence on s_axis_valid; a write happens on a clk edge where valid && ready.
REQ-016 SHALL store {last, data} per entry; with full && valid, the write SHALL NOT occur and nothing SHALL be dropped or corrupted.
REQ-017 SHALL allow a simultaneous write and pop when not full/empty (level unchanged); when empty, a write SHALL NOT pop in the same cycle.
REQ-018 SHALL compute DIV = round(CLK_RATE/BAUD) at elaboration; each line bit lasts exactly DIV clk cycles.
REQ-019 SHALL use FSM states IDLE, START, DATA, PARITY, STOP, GAP.
REQ-020 IDLE: when eligible, SHALL pop the head entry and go to START the next cycle; uart_tx is driven 0 from that cycle on.
REQ-021 Eligible SHALL mean: PKT_MODE=0 → FIFO not empty; PKT_MODE=1 → pkt_cnt>0, or FIFO full (to prevent deadlock).
REQ-022 pkt_cnt SHALL +1 on a write with last and -1 on a pop with last; both in the same cycle → unchanged; its width is clog2(FIFO_DEPTH)+1.
REQ-023 DATA SHALL send DATA_BITS bits LSB first.
REQ-024 PARITY SHALL be skipped when PARITY=0; otherwise it sends even parity (XOR of the data bits) or odd parity (inverted XOR).
REQ-025 STOP SHALL drive 1 for STOP_BITS×DIV cycles.
REQ-026 After STOP, GAP SHALL be entered iff the popped entry had last=1 and GAP_BITS>0; GAP holds 1 for GAP_BITS×DIV cycles, then IDLE; otherwise go directly to IDLE.
REQ-027 From STOP/GAP back-to-back, the next eligible frame SHALL start with exactly one IDLE cycle between frames (IDLE dwell = 1 clk).
REQ-028 uart_tx SHALL be registered (glitch-free) output.

Reset
REQ-029 While rst=0: uart_tx=1, state=IDLE, FIFO empty, fifo_level=0, pkt_cnt=0, tx_busy=0; s_axis_ready=0 during reset, 1 from the first cycle after release.
REQ-030 Reset asserted mid-frame SHALL abort immediately (uart_tx=1 asynchronously) and discard all FIFO contents.

Structure
REQ-031 SHALL place the FSM state encoding and the PARITY_NONE/EVEN/ODD constants in a shared package axis_uart_pkg.
REQ-032 SHALL instantiate one sub-module, uart_pkt_fifo (synchronous FIFO, DATA_BITS+1 wide, with level output); the FSM, baud counter, bit counter and pkt_cnt live in the top module.

Verification (CLK_RATE=1000000, BAUD=100000 → DIV=10)
REQ-033 SHALL cover: defaults-like 8N1, write 0xA5 → uart_tx low 10 clk, bits 1,0,1,0,0,1,0,1 at 10 clk each, high 10 clk; tx_busy high for 100 clk.
REQ-034 SHALL cover: PARITY=1 with 0x07 → parity bit 1; PARITY=2 with 0x07 → parity bit 0; STOP_BITS=2 → stop high 20 clk.
REQ-035 SHALL cover: FIFO_DEPTH=4, burst 6 writes with valid held → ready low after 4, fifo_level=4, all 6 bytes transmitted in order with none lost.
REQ-036 SHALL cover: PKT_MODE=1, write 3 bytes with last=0 → uart_tx stays 1; on the 4th byte with last=1 → the frame starts within 2 clk of the write.
REQ-037 SHALL cover: GAP_BITS=3, packet {0x11, 0x22(last)}, 0x33 queued → 30 clk idle after 0x22's stop bit before 0x33's start bit; no gap between 0x11 and 0x22 beyond 1 clk.
REQ-038 SHALL cover: rst pulsed low at bit 4 of a frame → uart_tx=1 at once, fifo_level=0 and s_axis_ready=1 after release, no further frame sent.
